atomrvcore_pipe_ctrl: RTL

Parametrised pipeline hazard controller for the atomRVCORE integer pipeline. It tracks up to DEPTH in-flight register writes downstream of decode. It drives operand forwarding and load-use stalls, and generates a multi-cycle front-end flush on taken branches and jumps. It sits beside the decoder: it consumes decoded register fields, and the decoder and fetch unit consume its stall and flush outputs.

---
 rtl/atomrvcore_pipe_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/atomrvcore_pipe_ctrl.sv
// Pipeline hazard controller: scoreboard of in-flight writes, operand forwarding, load-use stall, branch flush.
// Latency: forwarding/stall combinational (0 cycles); scoreboard/flush state update on rising clk_i.
// Backpressure: stall_o holds decode/fetch on load-use; flush_o squashes front end for FLUSH_CYCLES cycles.
module atomrvcore_pipe_ctrl #(
  parameter int DATAWIDTH        = 32,
  parameter int REG_ADRESS_WIDTH = 5,
  parameter int DEPTH            = 3,
  parameter int LOAD_STAGE       = 1,
  parameter int FLUSH_CYCLES     = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          issue_valid_i,
  input  logic                          issue_rwr_en_i,
  input  logic                          issue_load_i,
  input  logic [REG_ADRESS_WIDTH-1:0]   issue_rd_i,
  input  logic [REG_ADRESS_WIDTH-1:0]   rs1_i,
  input  logic [REG_ADRESS_WIDTH-1:0]   rs2_i,
  input  logic                          rs1_used_i,
  input  logic                          rs2_used_i,
  input  logic [DATAWIDTH-1:0]          rf_rs1_data_i,
  input  logic [DATAWIDTH-1:0]          rf_rs2_data_i,
  input  logic [DEPTH*DATAWIDTH-1:0]    stage_data_i,
  input  logic                          branch_taken_i,
  output logic                          stall_o,
  output logic                          flush_o,
  output logic [DATAWIDTH-1:0]          operand_A_o,
  output logic [DATAWIDTH-1:0]          operand_B_o,
  output logic [2:0]                    fwd_a_sel_o,
  output logic [2:0]                    fwd_b_sel_o,
  output logic [2:0]                    inflight_o
);

  // Scoreboard entries: index 0 is EX, DEPTH-1 is the oldest tracked stage.
  logic                        valid_q [DEPTH];
  logic [REG_ADRESS_WIDTH-1:0] rd_q    [DEPTH];
  logic                        load_q  [DEPTH];
  logic [3:0]                  flush_cnt_q;

  logic flush_idle;
  logic haz_a;
  logic haz_b;
  logic issue_ok;

  assign flush_idle = (flush_cnt_q == 4'd0);
  assign flush_o    = !flush_idle;

  // Hazard only when a real instruction is presented and no redirect is in progress;
  // a branch in the same cycle squashes the dependent instruction instead of stalling it.
  assign stall_o  = issue_valid_i & (haz_a | haz_b) & ~branch_taken_i & flush_idle;

  // x0 writers never occupy an entry, so reads of x0 can never match.
  assign issue_ok = issue_valid_i & issue_rwr_en_i & (issue_rd_i != '0) &
                    ~stall_o & ~branch_taken_i & flush_idle;

  // Forwarding select per source: walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_a_sel_o = 3'd0;
    fwd_b_sel_o = 3'd0;
    operand_A_o = rf_rs1_data_i;
    operand_B_o = rf_rs2_data_i;
    haz_a       = 1'b0;
    haz_b       = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && (rd_q[k] == rs1_i) && (rs1_i != '0) && rs1_used_i) begin
        if (load_q[k] && (k < LOAD_STAGE)) begin
          // Load data not yet available: the hazard masks any older match.
          haz_a       = 1'b1;
          fwd_a_sel_o = 3'd0;
          operand_A_o = rf_rs1_data_i;
        end else begin
          haz_a       = 1'b0;
          fwd_a_sel_o = 3'(k + 1);
          operand_A_o = stage_data_i[k*DATAWIDTH +: DATAWIDTH];
        end
      end
      if (valid_q[k] && (rd_q[k] == rs2_i) && (rs2_i != '0) && rs2_used_i) begin
        if (load_q[k] && (k < LOAD_STAGE)) begin
          haz_b       = 1'b1;
          fwd_b_sel_o = 3'd0;
          operand_B_o = rf_rs2_data_i;
        end else begin
          haz_b       = 1'b0;
          fwd_b_sel_o = 3'(k + 1);
          operand_B_o = stage_data_i[k*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  // Count of valid entries in the current scoreboard state.
  always_comb begin
    inflight_o = 3'd0;
    for (int k = 0; k < DEPTH; k++) begin
      inflight_o = inflight_o + {2'b00, valid_q[k]};
    end
  end

  // Scoreboard shift: entry 0 takes the accepted issue or a bubble, older entries advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        rd_q[k]    <= '0;
        load_q[k]  <= 1'b0;
      end
    end else begin
      valid_q[0] <= issue_ok;
      rd_q[0]    <= issue_ok ? issue_rd_i : '0;
      load_q[0]  <= issue_ok & issue_load_i;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        load_q[k]  <= load_q[k-1];
      end
    end
  end

  // Flush counter: a taken branch arms it only when idle, then it counts down to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_cnt_q <= 4'd0;
    end else if (!flush_idle) begin
      flush_cnt_q <= flush_cnt_q - 4'd1;
    end else if (branch_taken_i) begin
      flush_cnt_q <= 4'(FLUSH_CYCLES);
    end
  end

endmodule
